// File: rtl/sysram_arbiter.sv
// SysRAM arbiter: two masters (0 = instruction fetch, 1 = data) share one
// single-port SysRAM. The arbiter accepts one access per cycle and returns each
// response one cycle later. Uncontended requests are granted directly; contended
// requests alternate round-robin. The data master can hold a bounded lock to keep
// a read-modify-write sequence contiguous.
module sysram_arbiter #(
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned LOCK_MAX = 4    // 1..15
) (
   input  logic              clock,
   input  logic              reset,

   // Master 0: instruction fetch
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   input  logic [3:0]        m0_req_wstrb,
   input  logic [31:0]       m0_req_wdata,
   output logic              m0_resp_valid,
   output logic [31:0]       m0_resp_rdata,

   // Master 1: data
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   input  logic [3:0]        m1_req_wstrb,
   input  logic [31:0]       m1_req_wdata,
   input  logic              m1_req_lock,
   output logic              m1_resp_valid,
   output logic [31:0]       m1_resp_rdata,

   // SysRAM command port
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   // A lock of length 1 is just a normal grant, so the FSM never enters LOCKED.
   localparam bit        LockEnable = (LOCK_MAX > 1);
   localparam logic [4:0] LockMax5  = 5'(LOCK_MAX);

   lock_state_t lock_state;
   logic [3:0]  lock_cnt;
   logic        last_grant;   // 1 = master 1 was granted last
   logic        grant0;
   logic        grant1;
   logic        resp_valid0;
   logic        resp_valid1;
   logic        resp_read0;
   logic        resp_read1;
   logic [4:0]  lock_cnt_inc;

   assign lock_cnt_inc = {1'b0, lock_cnt} + 5'd1;

   // Grant decision; gating on reset keeps ready and the RAM command low
   // asynchronously while reset is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset) begin
         if (lock_state == LOCKED) begin
            grant1 = m1_req_valid;
         end else if (m0_req_valid && m1_req_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = m0_req_valid;
            grant1 = m1_req_valid;
         end
      end
   end

   assign m0_req_ready = grant0;
   assign m1_req_ready = grant1;

   // RAM command is driven from the accepted master only in the accept cycle.
   always_comb begin
      ram_en    = grant0 | grant1;
      ram_we    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (grant0) begin
         ram_we    = m0_req_wstrb;
         ram_addr  = m0_req_addr;
         ram_wdata = m0_req_wdata;
      end else if (grant1) begin
         ram_we    = m1_req_wstrb;
         ram_addr  = m1_req_addr;
         ram_wdata = m1_req_wdata;
      end
   end

   // Lock FSM with round-robin history; last_grant resets to 1 so m0 wins first.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lock_state <= UNLOCKED;
         lock_cnt   <= '0;
         last_grant <= 1'b1;
      end else begin
         if (grant0 || grant1) begin
            last_grant <= grant1;
         end
         unique case (lock_state)
            UNLOCKED: begin
               if (LockEnable && grant1 && m1_req_lock) begin
                  lock_state <= LOCKED;
                  lock_cnt   <= 4'd1;
               end
            end
            LOCKED: begin
               if (!m1_req_valid || !m1_req_lock) begin
                  // Master 1 went idle or asked for its last locked access.
                  lock_state <= UNLOCKED;
                  lock_cnt   <= '0;
               end else if (lock_cnt_inc >= LockMax5) begin
                  // Forced release: hand the next contended cycle to m0.
                  lock_state <= UNLOCKED;
                  lock_cnt   <= '0;
                  last_grant <= 1'b1;
               end else begin
                  lock_cnt <= lock_cnt_inc[3:0];
               end
            end
            default: begin
               lock_state <= UNLOCKED;
               lock_cnt   <= '0;
            end
         endcase
      end
   end

   // Response tracking: one cycle after accept; reset drops anything in flight.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_valid0 <= 1'b0;
         resp_valid1 <= 1'b0;
         resp_read0  <= 1'b0;
         resp_read1  <= 1'b0;
      end else begin
         resp_valid0 <= grant0;
         resp_valid1 <= grant1;
         resp_read0  <= grant0 && (m0_req_wstrb == 4'h0);
         resp_read1  <= grant1 && (m1_req_wstrb == 4'h0);
      end
   end

   assign m0_resp_valid = resp_valid0;
   assign m1_resp_valid = resp_valid1;
   assign m0_resp_rdata = resp_read0 ? ram_rdata : 32'h0;
   assign m1_resp_rdata = resp_read1 ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_sysram_arbiter.sv
// Bench for sysram_arbiter: directed scenarios followed by randomized traffic.
// A behavioural SRAM answers RAM commands, and a shadow memory plus a grant-rule
// model predict the ready, RAM command and response for every cycle.
module tb_sysram_arbiter;

   localparam int AddrW   = 12;
   localparam int LockMax = 4;
   localparam int Words   = 1 << AddrW;

   logic             clock;
   logic             reset;
   logic             m0_req_valid, m0_req_ready, m0_resp_valid;
   logic [AddrW-1:0] m0_req_addr;
   logic [3:0]       m0_req_wstrb;
   logic [31:0]      m0_req_wdata, m0_resp_rdata;
   logic             m1_req_valid, m1_req_ready, m1_resp_valid, m1_req_lock;
   logic [AddrW-1:0] m1_req_addr;
   logic [3:0]       m1_req_wstrb;
   logic [31:0]      m1_req_wdata, m1_resp_rdata;
   logic             ram_en;
   logic [3:0]       ram_we;
   logic [AddrW-1:0] ram_addr;
   logic [31:0]      ram_wdata, ram_rdata;

   sysram_arbiter #(.ADDR_W(AddrW), .LOCK_MAX(LockMax)) dut (
      .clock         (clock),
      .reset         (reset),
      .m0_req_valid  (m0_req_valid),
      .m0_req_ready  (m0_req_ready),
      .m0_req_addr   (m0_req_addr),
      .m0_req_wstrb  (m0_req_wstrb),
      .m0_req_wdata  (m0_req_wdata),
      .m0_resp_valid (m0_resp_valid),
      .m0_resp_rdata (m0_resp_rdata),
      .m1_req_valid  (m1_req_valid),
      .m1_req_ready  (m1_req_ready),
      .m1_req_addr   (m1_req_addr),
      .m1_req_wstrb  (m1_req_wstrb),
      .m1_req_wdata  (m1_req_wdata),
      .m1_req_lock   (m1_req_lock),
      .m1_resp_valid (m1_resp_valid),
      .m1_resp_rdata (m1_resp_rdata),
      .ram_en        (ram_en),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'h0000_0013;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Behavioural single-port SRAM, read data one cycle after ram_en.
   logic [31:0] mem [Words];
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < Words; i++) mem[i] <= init_word(i);
      end else if (ram_en) begin
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= mem[ram_addr];
      end
   end

   // Reference state
   logic [31:0] shadow [Words];
   bit          m_locked;
   int          m_run;
   int          m_last;
   bit          exp_rv0, exp_rv1;
   logic [31:0] exp_rd0, exp_rd1;
   int          m0_wait;
   int          checks;
   int          failures;
   logic        obs_r0, obs_r1;
   logic [31:0] obs_rd0, obs_rd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < Words; i++) shadow[i] = init_word(i);
      m_locked = 0;
      m_run    = 0;
      m_last   = 1;
      exp_rv0  = 0;
      exp_rv1  = 0;
      exp_rd0  = 0;
      exp_rd1  = 0;
      m0_wait  = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_m0_ready"}, m0_req_ready, 0);
      chk({tag, "_m1_ready"}, m1_req_ready, 0);
      chk({tag, "_m0_rv"}, m0_resp_valid, 0);
      chk({tag, "_m1_rv"}, m1_resp_valid, 0);
      chk({tag, "_m0_rdata"}, m0_resp_rdata, 0);
      chk({tag, "_m1_rdata"}, m1_resp_rdata, 0);
      chk({tag, "_ram_en"}, ram_en, 0);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_addr"}, ram_addr, 0);
      chk({tag, "_ram_wdata"}, ram_wdata, 0);
   endtask

   // Who should win this cycle: -1 none, 0 or 1.
   function automatic int exp_grant(input bit v0, input bit v1);
      if (m_locked) return v1 ? 1 : -1;
      if (v0 && v1) return (m_last == 1) ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   // One clock cycle: called just after a rising edge, returns just after the next.
   task automatic step(input bit v0, input logic [AddrW-1:0] a0, input logic [3:0] w0,
                       input logic [31:0] d0, input bit v1, input logic [AddrW-1:0] a1,
                       input logic [3:0] w1, input logic [31:0] d1, input bit lk,
                       output int g);
      logic [AddrW-1:0] ea;
      logic [3:0]       ew;
      logic [31:0]      ed;
      m0_req_valid = v0; m0_req_addr = a0; m0_req_wstrb = w0; m0_req_wdata = d0;
      m1_req_valid = v1; m1_req_addr = a1; m1_req_wstrb = w1; m1_req_wdata = d1;
      m1_req_lock  = lk;
      @(negedge clock);
      g  = exp_grant(v0, v1);
      ea = (g == 0) ? a0 : (g == 1) ? a1 : '0;
      ew = (g == 0) ? w0 : (g == 1) ? w1 : '0;
      ed = (g == 0) ? d0 : (g == 1) ? d1 : '0;
      obs_r0 = m0_req_ready; obs_r1 = m1_req_ready;
      obs_rd0 = m0_resp_rdata; obs_rd1 = m1_resp_rdata;
      chk("m0_ready", m0_req_ready, g == 0);
      chk("m1_ready", m1_req_ready, g == 1);
      chk("ram_en", ram_en, g >= 0);
      chk("ram_addr", ram_addr, ea);
      chk("ram_we", ram_we, ew);
      chk("ram_wdata", ram_wdata, ed);
      chk("m0_resp_valid", m0_resp_valid, exp_rv0);
      chk("m1_resp_valid", m1_resp_valid, exp_rv1);
      chk("m0_resp_rdata", m0_resp_rdata, exp_rd0);
      chk("m1_resp_rdata", m1_resp_rdata, exp_rd1);
      if (v0 && !m0_req_ready) m0_wait++;
      else if (v0) begin
         chk("m0_wait_bound", m0_wait + 1 <= LockMax + 1, 1);
         m0_wait = 0;
      end else m0_wait = 0;
      @(posedge clock);
      exp_rv0 = (g == 0); exp_rv1 = (g == 1);
      exp_rd0 = 0;        exp_rd1 = 0;
      if (g >= 0) begin
         if (ew == 4'h0) begin
            if (g == 0) exp_rd0 = shadow[ea];
            else        exp_rd1 = shadow[ea];
         end else begin
            for (int b = 0; b < 4; b++) if (ew[b]) shadow[ea][8*b +: 8] = ed[8*b +: 8];
         end
         m_last = g;
      end
      // Lock rules: a run of at most LockMax consecutive locked m1 grants.
      if (m_locked) begin
         if (!v1 || !lk) m_locked = 0;
         else begin
            m_run++;
            if (m_run >= LockMax) begin m_locked = 0; m_last = 1; end
         end
      end else if (g == 1 && lk) begin
         m_run    = 1;
         m_locked = (m_run < LockMax);
      end
      #1;
   endtask

   int g;
   int grants[$];
   bit p0, p1;
   logic [AddrW-1:0] ra0, ra1;
   logic [3:0]  rw0, rw1;
   logic [31:0] rd0, rd1;

   initial begin
      checks = 0; failures = 0;
      reset = 1'b0;
      m0_req_valid = 1; m0_req_addr = 0; m0_req_wstrb = 0; m0_req_wdata = 0;
      m1_req_valid = 1; m1_req_addr = 0; m1_req_wstrb = 0; m1_req_wdata = 0;
      m1_req_lock  = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk_all_zero("reset");
      reset = 1'b1;

      // Both masters valid for six cycles: strict alternation, m0 first.
      for (int k = 0; k < 6; k++) begin
         step(1, 12'(k), 0, 0, 1, 12'(k + 8), 0, 0, 0, g);
         chk("alt_grant_m0", obs_r0, (k % 2) == 0);
         chk("alt_grant_m1", obs_r1, (k % 2) == 1);
      end

      // m0 read of preloaded word.
      step(1, 12'h010, 0, 0, 0, 0, 0, 0, 0, g);
      chk("read010_ready", obs_r0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("read010_rdata", obs_rd0, 32'h0000_0013);

      // m1 write then m0 read of same word.
      step(0, 0, 0, 0, 1, 12'h020, 4'hF, 32'hDEAD_BEEF, 0, g);
      step(1, 12'h020, 0, 0, 0, 0, 0, 0, 0, g);
      chk("wr020_ack_rdata", obs_rd1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("rd020_rdata", obs_rd0, 32'hDEAD_BEEF);

      // Partial write merges with old contents.
      step(0, 0, 0, 0, 1, 12'h030, 4'hF, 32'hAAAA_AAAA, 0, g);
      step(0, 0, 0, 0, 1, 12'h030, 4'h3, 32'h1122_3344, 0, g);
      step(1, 12'h030, 0, 0, 0, 0, 0, 0, 0, g);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
      chk("wstrb_merge", obs_rd0, 32'hAAAA_3344);

      // Lock: last grant was m0, so m1 wins and holds for LockMax cycles.
      step(1, 12'h040, 0, 0, 0, 0, 0, 0, 0, g);
      grants = {};
      p0 = 1;
      for (int k = 0; k < 8; k++) begin
         step(p0, 12'h050, 0, 0, 1, 12'(12'h060 + k), 0, 0, 1, g);
         grants.push_back(g);
         if (g == 0) p0 = 0;
      end
      for (int k = 0; k < 5; k++) chk("lock_grant_seq", 32'(grants[k]), (k < 4) ? 1 : 0);

      // Reset the cycle after an m0 read accept.
      step(1, 12'h010, 0, 0, 0, 0, 0, 0, 0, g);
      reset = 1'b0;
      model_reset();
      m1_req_valid = 1;
      #1;
      chk_all_zero("midreset");
      @(negedge clock);
      chk("midreset_m0_ready", m0_req_ready, 0);
      chk("midreset_m1_ready", m1_req_ready, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
      step(1, 12'h010, 0, 0, 0, 0, 0, 0, 0, g);
      chk("post_reset_accept", obs_r0, 1);

      // Randomized traffic; requests are held until accepted.
      p0 = 0; p1 = 0;
      ra0 = 0; ra1 = 0; rw0 = 0; rw1 = 0; rd0 = 0; rd1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!p0 && $urandom_range(0, 3) != 0) begin
            p0 = 1; ra0 = 12'($urandom_range(0, 15)); rd0 = $urandom;
            rw0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         end
         if (!p1 && $urandom_range(0, 3) != 0) begin
            p1 = 1; ra1 = 12'($urandom_range(0, 15)); rd1 = $urandom;
            rw1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         end
         step(p0, ra0, rw0, rd0, p1, ra1, rw1, rd1, $urandom_range(0, 3) != 0, g);
         if (g == 0) p0 = 0;
         if (g == 1) p1 = 0;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
